image_scan_tx: RTL and testbench

IMAGE_SCAN_TX -- requirements
Module: image_scan_tx

---
 rtl/image_scan_tx.sv | 146 ++++++++++++++
 tb/tb_image_scan_tx.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/image_scan_tx.sv
// Reads one frame in raster order and streams each pixel, optionally inverted or grayscaled.
// Each pixel takes 3 cycles (read, data return, send). px_ready low holds the pixel and pauses reads.
module image_scan_tx #(
  parameter int IMG_W = 4,
  parameter int IMG_H = 3,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    mode,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [23:0]   mem_rdata,
  output logic [23:0]   px_data,
  output logic          px_valid,
  input  logic          px_ready,
  output logic          px_sof,
  output logic          px_eol,
  output logic          px_eof,
  output logic          busy,
  output logic          done
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  typedef enum logic [2:0] {IDLE, RD, LAT, SEND, FIN} state_t;

  state_t        r_state;
  logic [1:0]    r_mode;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [AW-1:0] r_addr;
  logic          r_rd_en;
  logic [23:0]   r_px_data;
  logic          r_px_valid;
  logic          r_sof;
  logic          r_eol;
  logic          r_eof;
  logic          r_busy;
  logic          r_done;

  logic [9:0]    w_sum;
  logic [23:0]   w_pix;
  logic          w_x_last;
  logic          w_y_last;

  assign w_x_last = (r_x == XW'(IMG_W - 1));
  assign w_y_last = (r_y == YW'(IMG_H - 1));

  // R + 2G + B fits in 10 bits; the gray level is the top 8 of them.
  assign w_sum = {2'b00, mem_rdata[23:16]} + {1'b0, mem_rdata[15:8], 1'b0} + {2'b00, mem_rdata[7:0]};

  always_comb begin
    w_pix = mem_rdata;
    case (r_mode)
      2'b01:   w_pix = ~mem_rdata;
      2'b10:   w_pix = {w_sum[9:2], w_sum[9:2], w_sum[9:2]};
      default: w_pix = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_mode     <= 2'b00;
      r_x        <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_rd_en    <= 1'b0;
      r_px_data  <= '0;
      r_px_valid <= 1'b0;
      r_sof      <= 1'b0;
      r_eol      <= 1'b0;
      r_eof      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mode  <= mode;
            r_x     <= '0;
            r_y     <= '0;
            r_addr  <= '0;
            r_busy  <= 1'b1;
            r_rd_en <= 1'b1;
            r_state <= RD;
          end
        end
        RD: begin
          r_rd_en <= 1'b0;
          r_state <= LAT;
        end
        LAT: begin
          r_px_data  <= w_pix;
          r_sof      <= (r_x == '0) && (r_y == '0);
          r_eol      <= w_x_last;
          r_eof      <= w_x_last && w_y_last;
          r_px_valid <= 1'b1;
          r_state    <= SEND;
        end
        SEND: begin
          if (px_ready) begin
            r_px_valid <= 1'b0;
            if (w_x_last && w_y_last) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              // Raster order means the address simply advances by one per pixel.
              r_addr  <= r_addr + AW'(1);
              r_rd_en <= 1'b1;
              r_state <= RD;
              if (w_x_last) begin
                r_x <= '0;
                r_y <= r_y + YW'(1);
              end else begin
                r_x <= r_x + XW'(1);
              end
            end
          end
        end
        FIN: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign mem_rd_en = r_rd_en;
  assign mem_addr  = r_addr;
  assign px_data   = r_px_data;
  assign px_valid  = r_px_valid;
  assign px_sof    = r_sof;
  assign px_eol    = r_eol;
  assign px_eof    = r_eof;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_image_scan_tx.sv
// Directed bench for image_scan_tx: 4x3 frame, transform modes, backpressure, ignored start, mid-frame reset.
module tb_image_scan_tx;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int N  = W * H;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [23:0]   mem_rdata = '0;
  logic [23:0]   px_data;
  logic          px_valid;
  logic          px_ready = 1'b1;
  logic          px_sof;
  logic          px_eol;
  logic          px_eof;
  logic          busy;
  logic          done;

  image_scan_tx #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .px_data(px_data), .px_valid(px_valid), .px_ready(px_ready),
    .px_sof(px_sof), .px_eol(px_eol), .px_eof(px_eof),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [23:0] mem [N];
  int          rd_addrs[$];
  logic [26:0] cap[$];
  int          checks = 0;
  int          failures = 0;

  // Frame memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= mem[mem_addr];
      rd_addrs.push_back(int'(mem_addr));
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_mem(input logic [23:0] first, input logic [23:0] rest);
    for (int i = 0; i < N; i++) mem[i] = (i == 0) ? first : rest;
  endtask

  // Runs one frame; optional 5-cycle stall on pixel stall_pix and start/mode pulse during pixel inj_pix.
  task automatic do_frame(input logic [1:0] m, input int stall_pix, input int inj_pix,
                          output int cyc, output int ndone);
    int          stall;
    logic [26:0] snap;
    logic [26:0] cur;
    cap.delete();
    rd_addrs.delete();
    stall = 0;
    ndone = 0;
    snap  = '0;
    mode  = m;
    start = 1'b1;
    px_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    mode  = m ^ 2'b01;
    cyc   = 0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    while (cyc < 300) begin
      cur = {px_sof, px_eol, px_eof, px_data};
      if (px_valid && cap.size() == stall_pix && stall < 5) begin
        px_ready = 1'b0;
        if (stall == 0) snap = cur;
        else chk("stall_hold", {36'd0, cur, mem_rd_en}, {36'd0, snap, 1'b0});
        stall++;
      end else begin
        px_ready = 1'b1;
      end
      if (px_valid && px_ready) cap.push_back(cur);
      if (inj_pix >= 0 && cap.size() == inj_pix) begin
        start = 1'b1;
        mode  = 2'b01;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        ndone++;
        break;
      end
    end
    start = 1'b0;
    chk("done_reached", {63'd0, done}, 64'd1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
  endtask

  task automatic check_pix(input string tag, input logic [23:0] e0, input logic [23:0] erest);
    logic [26:0] exp;
    chk({tag, "_count"}, cap.size(), N);
    for (int i = 0; i < N && i < cap.size(); i++) begin
      exp = {(i == 0), (i % W == W - 1), (i == N - 1), (i == 0) ? e0 : erest};
      chk($sformatf("%s_pix%0d", tag, i), {37'd0, cap[i]}, {37'd0, exp});
    end
  endtask

  task automatic check_reads(input string tag);
    logic ok;
    ok = (rd_addrs.size() == N);
    for (int i = 0; i < rd_addrs.size(); i++) if (rd_addrs[i] != i) ok = 1'b0;
    chk({tag, "_rd_seq"}, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    int cyc;
    int nd;
    int hs;
    fill_mem(24'hFF0000, 24'h0000FF);
    #12;
    chk("reset_outputs", {34'd0, px_valid, px_data, px_sof, px_eol, px_eof, mem_rd_en, mem_addr, busy, done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pass-through, full rate
    do_frame(2'b00, -1, -1, cyc, nd);
    check_pix("pass", 24'hFF0000, 24'h0000FF);
    chk("pass_cycles", cyc, 36);
    chk("pass_done_once", nd, 1);
    chk("pass_busy_low", {63'd0, busy}, 64'd0);
    check_reads("pass");

    // Invert
    do_frame(2'b01, -1, -1, cyc, nd);
    check_pix("inv", 24'h00FFFF, 24'hFFFF00);
    chk("inv_done_once", nd, 1);

    // Grayscale: 0x0000FF->0x3F3F3F, 0xFFFFFF->0xFFFFFF, 0x808000->0x606060
    for (int i = 0; i < N; i++) mem[i] = 24'h000000;
    mem[0]  = 24'h0000FF;
    mem[5]  = 24'hFFFFFF;
    mem[11] = 24'h808000;
    do_frame(2'b10, -1, -1, cyc, nd);
    chk("gray_count", cap.size(), N);
    if (cap.size() == N) begin
      chk("gray_pix0", {40'd0, cap[0][23:0]}, 64'h3F3F3F);
      chk("gray_pix5", {40'd0, cap[5][23:0]}, 64'hFFFFFF);
      chk("gray_pix11", {40'd0, cap[11][23:0]}, 64'h606060);
      chk("gray_pix1", {40'd0, cap[1][23:0]}, 64'h000000);
      chk("gray_pix11_flags", {61'd0, cap[11][26:24]}, 64'b011);
    end

    // Backpressure on pixel 2
    fill_mem(24'hFF0000, 24'h0000FF);
    do_frame(2'b00, 2, -1, cyc, nd);
    check_pix("stall", 24'hFF0000, 24'h0000FF);
    chk("stall_cycles", cyc, 41);
    chk("stall_done_once", nd, 1);
    check_reads("stall");

    // Start with mode=01 mid-frame is ignored
    do_frame(2'b00, -1, 5, cyc, nd);
    check_pix("inj", 24'hFF0000, 24'h0000FF);
    chk("inj_done_once", nd, 1);
    chk("inj_cycles", cyc, 36);

    // Reset during pixel 6
    mode = 2'b00;
    start = 1'b1;
    px_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hs = 0;
    for (int c = 0; c < 100; c++) begin
      if (px_valid && hs == 6) break;
      if (px_valid && px_ready) hs++;
      @(posedge clk); #1;
    end
    chk("rst_reached_pix6", {63'd0, px_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {34'd0, px_valid, px_data, px_sof, px_eol, px_eof, mem_rd_en, mem_addr, busy, done}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    chk("midrst_hold", {34'd0, px_valid, px_data, px_sof, px_eol, px_eof, mem_rd_en, mem_addr, busy, done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_frame(2'b00, -1, -1, cyc, nd);
    chk("post_rst_first_addr", (rd_addrs.size() > 0) ? rd_addrs[0] : -1, 0);
    check_pix("post_rst", 24'hFF0000, 24'h0000FF);
    chk("post_rst_done_once", nd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
